// File: rtl/ram_sched_pkg.sv
// ram_sched_pkg: shared types for the RAM port scheduler.
// FSM states, grant codes and the ack pipeline depth.
package ram_sched_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  typedef enum logic [1:0] {
    G_NONE,
    G_VID,
    G_CPU,
    G_LD
  } grant_e;

  localparam int ACK_LAT = 1;

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: walks every RAM address once per clear pass.
// Owns the CLEAR/RUN state, the address counter and restart.
import ram_sched_pkg::*;

module ram_clear_seq #(
  parameter int AW             = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_start,
  output logic          o_busy,
  output logic [AW-1:0] o_addr,
  output logic          o_done
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic          w_last;

  assign w_last = (r_cnt == {AW{1'b1}});
  assign o_busy = (r_state == CLEAR);
  assign o_addr = r_cnt;

  // state and address counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if (CLEAR_ON_RESET) r_state <= CLEAR;
      else                r_state <= RUN;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // next state: start (re)arms at 0, terminal address ends the pass
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_done      = 1'b0;
    unique case (r_state)
      RUN: begin
        if (i_start) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (i_start) begin
          w_cnt_nxt = '0;
        end else if (w_last) begin
          w_state_nxt = RUN;
          o_done      = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_port_scheduler.sv
// ram_port_scheduler: shares one RAM port between video,
// CPU and loader, with a fill pass after reset or on request.
import ram_sched_pkg::*;

module ram_port_scheduler #(
  parameter int          AW             = 12,
  parameter int          DW             = 8,
  parameter logic [DW-1:0] FILL         = '0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic [DW-1:0] rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic [AW-1:0] w_clr_addr;
  logic          w_clr_done;
  logic          w_clr;
  logic          w_run;
  logic          w_ev;
  logic          w_ec;
  logic          w_el;
  grant_e        w_gnt;
  grant_e        r_prev;
  logic          r_rr_ld;
  logic [2:0]    w_ack;
  logic [2:0]    r_ack [ACK_LAT];

  ram_clear_seq #(
    .AW             (AW),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (clr_start),
    .o_busy  (clr_busy),
    .o_addr  (w_clr_addr),
    .o_done  (w_clr_done)
  );

  // nothing reaches the RAM while reset is held
  assign w_clr = reset_n & clr_busy;
  assign w_run = reset_n & ~clr_busy;

  assign w_ev = vid_req & (r_prev != G_VID);
  assign w_ec = cpu_req & (r_prev != G_CPU);
  assign w_el = ld_req  & (r_prev != G_LD);

  // grant: video first, then CPU/loader round-robin
  always_comb begin
    w_gnt = G_NONE;
    if (w_run) begin
      if (w_ev)              w_gnt = G_VID;
      else if (w_ec && w_el) w_gnt = r_rr_ld ? G_LD : G_CPU;
      else if (w_ec)         w_gnt = G_CPU;
      else if (w_el)         w_gnt = G_LD;
    end
  end

  // previous grant and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev  <= G_NONE;
      r_rr_ld <= 1'b0;
    end else begin
      r_prev <= w_clr_done ? G_NONE : w_gnt;
      if (w_gnt == G_CPU) r_rr_ld <= 1'b1;
      if (w_gnt == G_LD)  r_rr_ld <= 1'b0;
    end
  end

  assign w_ack = {w_gnt == G_VID,
                  w_gnt == G_CPU,
                  w_gnt == G_LD};

  // ack pipeline, one stage per cycle of latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ACK_LAT; i++)
        r_ack[i] <= '0;
    end else begin
      r_ack[0] <= w_ack;
      for (int i = 1; i < ACK_LAT; i++)
        r_ack[i] <= r_ack[i-1];
    end
  end

  assign vid_ack = r_ack[ACK_LAT-1][2];
  assign cpu_ack = r_ack[ACK_LAT-1][1];
  assign ld_ack  = r_ack[ACK_LAT-1][0];
  assign rdata   = ram_dout;

  // RAM port mux: clear pass owns the port while busy
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (w_clr) begin
      ram_we   = 1'b1;
      ram_addr = w_clr_addr;
      ram_din  = FILL;
    end else begin
      unique case (w_gnt)
        G_VID: ram_addr = vid_addr;
        G_CPU: begin
          ram_we   = cpu_we;
          ram_addr = cpu_addr;
          ram_din  = cpu_wdata;
        end
        G_LD: begin
          ram_we   = 1'b1;
          ram_addr = ld_addr;
          ram_din  = ld_wdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_scheduler.sv
// tb_ram_port_scheduler: directed bench for the RAM port scheduler.
// Drives a write-first RAM model and hand-computed expectations.
`timescale 1ns/1ps

module tb_ram_port_scheduler;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_ack;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic          ld_req = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          ld_ack;
  logic          clr_start = 1'b0;
  logic          clr_busy;
  logic [DW-1:0] rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_port_scheduler #(
    .AW (AW),
    .DW (DW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_ack   (vid_ack),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_ack    (ld_ack),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .rdata     (rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // RAM model: preset to FF, then write-first registered read
  logic [DW-1:0] mem [DEPTH];
  logic          mem_rdy = 1'b0;

  always @(posedge clk) begin
    if (!mem_rdy) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
      mem_rdy  <= 1'b1;
      ram_dout <= '0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= ram_we ? ram_din : mem[ram_addr];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // count cycles with clr_busy high, and any acks seen meanwhile
  task automatic wait_clear(output int n, output int acks);
    n = 0;
    acks = 0;
    while (clr_busy && n < 5000) begin
      n++;
      @(negedge clk);
      if (clr_busy)
        acks += int'(vid_ack) + int'(cpu_ack) + int'(ld_ack);
    end
  endtask

  task automatic cpu_rw(input logic we,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d,
                        output logic [DW-1:0] q,
                        output bit ok);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cpu_ack) ok = 1'b1;
    end
    q = rdata;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    @(negedge clk);
  endtask

  function automatic int count_nonfill();
    int nz = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== 8'h00) nz++;
    return nz;
  endfunction

  int            n;
  int            a;
  int            li;
  int            nv;
  int            wr;
  bit            ok;
  bit            vdone;
  logic [DW-1:0] q;
  logic [DW-1:0] exp0;
  logic [2:0]    seq [8];

  initial begin
    seq = '{3'b100, 3'b010, 3'b100, 3'b001,
            3'b100, 3'b010, 3'b100, 3'b001};

    // 1: reset state, clear pass, held CPU read
    repeat (3) @(negedge clk);
    chk("rst_busy", clr_busy, 1);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_acks", {vid_ack, cpu_ack, ld_ack}, 0);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 12'h005;
    reset_n = 1'b1;
    wait_clear(n, a);
    chk("t1_clr_len", n, DEPTH);
    chk("t1_clr_noack", a, 0);
    chk("t1_gnt_addr", ram_addr, 12'h005);
    chk("t1_gnt_we", ram_we, 0);
    chk("t1_ack_early", cpu_ack, 0);
    @(negedge clk);
    chk("t1_ack", cpu_ack, 1);
    chk("t1_rdata", rdata, 8'h00);
    cpu_req = 1'b0;
    chk("t1_fill", count_nonfill(), 0);

    // 2: CPU write then read back, 1-cycle ack
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 12'h123;
    cpu_wdata = 8'hA5;
    #1;
    chk("t2_wr_we", ram_we, 1);
    chk("t2_wr_addr", ram_addr, 12'h123);
    chk("t2_wr_din", ram_din, 8'hA5);
    @(negedge clk);
    chk("t2_wr_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    @(negedge clk);
    chk("t2_wr_ack_once", cpu_ack, 0);
    cpu_req = 1'b1;
    #1;
    chk("t2_rd_we", ram_we, 0);
    chk("t2_rd_addr", ram_addr, 12'h123);
    @(negedge clk);
    chk("t2_rd_ack", cpu_ack, 1);
    chk("t2_rd_data", rdata, 8'hA5);
    cpu_req = 1'b0;
    @(negedge clk);

    // 4: loader fills 0..255 while video polls address 0
    cpu_rw(1'b1, 12'h000, 8'hEE, q, ok);
    chk("t4_pre_ok", ok, 1);
    vid_req = 1'b1;
    vid_addr = '0;
    ld_req = 1'b1;
    ld_addr = '0;
    ld_wdata = '0;
    li = 0;
    nv = 0;
    wr = 0;
    exp0 = 8'hEE;
    for (int c = 0; c < 2000 && li < 256; c++) begin
      @(negedge clk);
      if (ram_we) wr++;
      if (vid_ack) begin
        chk("t4_vid", rdata, exp0);
        nv++;
      end
      if (ld_ack) begin
        if (li == 0) exp0 = 8'h00;
        li++;
        ld_addr = AW'(li);
        ld_wdata = DW'(li);
        if (li == 256) ld_req = 1'b0;
      end
    end
    vdone = 1'b0;
    for (int c = 0; c < 4 && !vdone; c++) begin
      @(negedge clk);
      if (vid_ack) vdone = 1'b1;
    end
    vid_req = 1'b0;
    chk("t4_ld_cnt", li, 256);
    chk("t4_wr_cnt", wr, 256);
    chk("t4_vid_cnt", nv, 256);
    chk("t4_vid_last", vdone, 1);
    a = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== DW'(i)) a++;
    chk("t4_mem", a, 0);
    @(negedge clk);

    // 3: all three held: VID CPU VID LD VID CPU VID LD
    vid_addr = 12'h010;
    cpu_we = 1'b0;
    cpu_addr = 12'h020;
    ld_addr = 12'h200;
    ld_wdata = 8'h3C;
    vid_req = 1'b1;
    cpu_req = 1'b1;
    ld_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t3_ack%0d", i),
          {vid_ack, cpu_ack, ld_ack}, seq[i]);
    end
    vid_req = 1'b0;
    cpu_req = 1'b0;
    ld_req = 1'b0;
    repeat (2) @(negedge clk);

    // 5: clr_start in the CPU grant cycle
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 12'h123;
    clr_start = 1'b1;
    #1;
    chk("t5_gnt_addr", ram_addr, 12'h123);
    @(negedge clk);
    chk("t5_ack", cpu_ack, 1);
    chk("t5_rdata", rdata, 8'hA5);
    chk("t5_busy", clr_busy, 1);
    chk("t5_clr_addr", ram_addr, 0);
    cpu_req = 1'b0;
    clr_start = 1'b0;
    wait_clear(n, a);
    chk("t5_clr_len", n, DEPTH);
    chk("t5_clr_noack", a, 0);
    chk("t5_fill", count_nonfill(), 0);
    cpu_rw(1'b0, 12'h123, 8'h00, q, ok);
    chk("t5_rd123_ok", ok, 1);
    chk("t5_rd123", q, 8'h00);
    cpu_rw(1'b0, 12'hFFF, 8'h00, q, ok);
    chk("t5_rdfff_ok", ok, 1);
    chk("t5_rdfff", q, 8'h00);

    // 6: reset at counter 7 restarts the clear at 0
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (7) @(negedge clk);
    chk("t6_cnt7", ram_addr, 7);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_we", ram_we, 0);
    chk("t6_rst_addr", ram_addr, 0);
    chk("t6_rst_busy", clr_busy, 1);
    repeat (2) @(negedge clk);
    chk("t6_rst_acks", {vid_ack, cpu_ack, ld_ack}, 0);
    reset_n = 1'b1;
    #1;
    chk("t6_restart_addr", ram_addr, 0);
    chk("t6_restart_we", ram_we, 1);
    wait_clear(n, a);
    chk("t6_clr_len", n, DEPTH);
    chk("t6_fill", count_nonfill(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
